// File: rtl/block_sync_lane_supervisor.sv
// Supervisor for the per-lane block sync FSMs of the 100GbE RX PCS.
// It enables the lanes and shadows their configuration. It qualifies a stable
// all-lanes-locked condition, pulses the alignment/deskew start, forces
// per-lane resync on search timeout, and keeps saturating statistics.
// Ports:
//   i_clock, i_reset_n          clock, async active-low reset
//   i_enable, i_valid           tick = i_enable & i_valid
//   i_signal_ok                 PMA signal ok; low forces IDLE
//   i_lane_lock                 block_lock from each lane FSM
//   i_cfg_*                     timer/limit/timeout/qualify configuration
//   i_clear_stats               synchronous clear of the statistics
//   o_lane_enable/o_lane_reset  per-lane control
//   o_*_limit                   config shadows seen by the lanes
//   o_all_locked, o_align_start LOCKED status and entry pulse
//   o_state                     IDLE=0 SEARCH=1 QUALIFY=2 LOCKED=3 RESYNC=4
//   o_loss_count, o_timeout_count saturating event counters
module block_sync_lane_supervisor #(
    parameter int unsigned N_LANES        = 20,
    parameter int unsigned NB_WINDOW_CNT  = 11,
    parameter int unsigned NB_INVALID_CNT = 3,
    parameter int unsigned NB_TIMEOUT     = 16,
    parameter int unsigned NB_QUAL        = 8,
    parameter int unsigned NB_STAT        = 8,
    parameter int unsigned RESYNC_CYCLES  = 4
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_enable,
    input  logic                      i_valid,
    input  logic                      i_signal_ok,
    input  logic [N_LANES-1:0]        i_lane_lock,
    input  logic [NB_WINDOW_CNT-1:0]  i_cfg_unlocked_limit,
    input  logic [NB_WINDOW_CNT-1:0]  i_cfg_locked_limit,
    input  logic [NB_INVALID_CNT-1:0] i_cfg_invalid_limit,
    input  logic [NB_TIMEOUT-1:0]     i_cfg_timeout,
    input  logic [NB_QUAL-1:0]        i_cfg_qual,
    input  logic                      i_clear_stats,
    output logic [N_LANES-1:0]        o_lane_enable,
    output logic [N_LANES-1:0]        o_lane_reset,
    output logic [NB_WINDOW_CNT-1:0]  o_unlocked_timer_limit,
    output logic [NB_WINDOW_CNT-1:0]  o_locked_timer_limit,
    output logic [NB_INVALID_CNT-1:0] o_sh_invalid_limit,
    output logic                      o_all_locked,
    output logic                      o_align_start,
    output logic [2:0]                o_state,
    output logic [NB_STAT-1:0]        o_loss_count,
    output logic [NB_STAT-1:0]        o_timeout_count
);

    localparam int unsigned NB_RS = $clog2(RESYNC_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEARCH  = 3'd1,
        S_QUALIFY = 3'd2,
        S_LOCKED  = 3'd3,
        S_RESYNC  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [NB_TIMEOUT-1:0]  tmo_q, tmo_d;
    logic [NB_QUAL-1:0]     qual_q, qual_d;
    logic [NB_RS-1:0]       rs_q, rs_d;
    logic [N_LANES-1:0]     snap_q, snap_d;
    logic [NB_TIMEOUT:0]    tmo_nxt;
    logic [NB_QUAL:0]       qual_nxt;
    logic [NB_RS-1:0]       rs_nxt;
    logic                   tick, all_lock, loss_inc, tmo_inc;
    logic [N_LANES-1:0]     lane_en_d, lane_rst_d;
    logic [NB_STAT-1:0]     loss_d, tmo_stat_d;

    assign tick     = i_enable & i_valid;
    assign all_lock = &i_lane_lock;
    assign tmo_nxt  = {1'b0, tmo_q} + (NB_TIMEOUT + 1)'(1);
    assign qual_nxt = {1'b0, qual_q} + (NB_QUAL + 1)'(1);
    assign rs_nxt   = rs_q + NB_RS'(1);

    // Next-state, counter and registered-output decode
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        qual_d   = qual_q;
        rs_d     = rs_q;
        snap_d   = snap_q;
        loss_inc = 1'b0;
        tmo_inc  = 1'b0;
        if (!i_signal_ok) begin
            state_d = S_IDLE;
            tmo_d   = '0;
            qual_d  = '0;
            rs_d    = '0;
        end else if (tick) begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SEARCH;
                    tmo_d   = '0;
                end
                S_SEARCH: begin
                    // Saturate so a disabled timeout never wraps
                    tmo_d = (&tmo_q) ? tmo_q : tmo_nxt[NB_TIMEOUT-1:0];
                    if (all_lock) begin
                        state_d = S_QUALIFY;
                        qual_d  = '0;
                    end else if ((i_cfg_timeout != '0) && (tmo_nxt >= {1'b0, i_cfg_timeout})) begin
                        state_d = S_RESYNC;
                        rs_d    = '0;
                        snap_d  = i_lane_lock;
                        tmo_inc = 1'b1;
                    end
                end
                S_QUALIFY: begin
                    if (!all_lock) begin
                        state_d = S_SEARCH;
                        tmo_d   = '0;
                    end else begin
                        qual_d = qual_nxt[NB_QUAL-1:0];
                        // A zero qualify limit is met on the first tick
                        if (qual_nxt >= {1'b0, i_cfg_qual}) begin
                            state_d = S_LOCKED;
                        end
                    end
                end
                S_LOCKED: begin
                    if (!all_lock) begin
                        state_d  = S_SEARCH;
                        tmo_d    = '0;
                        loss_inc = 1'b1;
                    end
                end
                S_RESYNC: begin
                    if (rs_nxt >= NB_RS'(RESYNC_CYCLES)) begin
                        state_d = S_SEARCH;
                        tmo_d   = '0;
                        rs_d    = '0;
                    end else begin
                        rs_d = rs_nxt;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        lane_en_d  = (state_d == S_IDLE) ? '0 : '1;
        lane_rst_d = '0;
        if (state_d == S_IDLE) begin
            lane_rst_d = '1;
        end else if (state_d == S_RESYNC) begin
            // Only lanes that were unlocked at entry get reset
            lane_rst_d = ~snap_d;
        end

        loss_d = o_loss_count;
        if (i_clear_stats) begin
            loss_d = '0;
        end else if (loss_inc && !(&o_loss_count)) begin
            loss_d = o_loss_count + NB_STAT'(1);
        end
        tmo_stat_d = o_timeout_count;
        if (i_clear_stats) begin
            tmo_stat_d = '0;
        end else if (tmo_inc && !(&o_timeout_count)) begin
            tmo_stat_d = o_timeout_count + NB_STAT'(1);
        end
    end

    // State, counters, shadows and outputs
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q                <= S_IDLE;
            tmo_q                  <= '0;
            qual_q                 <= '0;
            rs_q                   <= '0;
            snap_q                 <= '0;
            o_lane_enable          <= '0;
            o_lane_reset           <= '0;
            o_unlocked_timer_limit <= '0;
            o_locked_timer_limit   <= '0;
            o_sh_invalid_limit     <= '0;
            o_all_locked           <= 1'b0;
            o_align_start          <= 1'b0;
            o_loss_count           <= '0;
            o_timeout_count        <= '0;
        end else begin
            state_q         <= state_d;
            tmo_q           <= tmo_d;
            qual_q          <= qual_d;
            rs_q            <= rs_d;
            snap_q          <= snap_d;
            o_lane_enable   <= lane_en_d;
            o_lane_reset    <= lane_rst_d;
            o_all_locked    <= (state_d == S_LOCKED);
            o_align_start   <= (state_q == S_QUALIFY) && (state_d == S_LOCKED);
            o_loss_count    <= loss_d;
            o_timeout_count <= tmo_stat_d;
            // Lanes only see new config while the block is idle
            if (state_q == S_IDLE) begin
                o_unlocked_timer_limit <= i_cfg_unlocked_limit;
                o_locked_timer_limit   <= i_cfg_locked_limit;
                o_sh_invalid_limit     <= i_cfg_invalid_limit;
            end
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_block_sync_lane_supervisor.sv
// Directed bench for block_sync_lane_supervisor with an expected-output queue.
module tb_block_sync_lane_supervisor;

    typedef struct packed {
        logic [2:0]  state;
        logic        all_locked;
        logic        align_start;
        logic [19:0] lane_enable;
        logic [19:0] lane_reset;
        logic [7:0]  loss;
        logic [7:0]  tmo;
        logic [10:0] unl;
        logic [10:0] lck;
        logic [2:0]  inv;
    } obs_t;

    localparam logic [2:0] IDLE = 3'd0, SEARCH = 3'd1, QUALIFY = 3'd2, LOCKED = 3'd3, RESYNC = 3'd4;
    localparam logic [19:0] ALL = 20'hFFFFF;

    logic        clk, rst_n, enable, valid, signal_ok, clear_stats;
    logic [19:0] lane_lock;
    logic [10:0] cfg_unl, cfg_lck;
    logic [2:0]  cfg_inv;
    logic [15:0] cfg_timeout;
    logic [7:0]  cfg_qual;
    logic [19:0] lane_enable, lane_reset;
    logic [10:0] unl_lim, lck_lim;
    logic [2:0]  inv_lim, state;
    logic        all_locked, align_start;
    logic [7:0]  loss_count, timeout_count;

    obs_t obs;
    obs_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    logic [7:0]  e_loss = 8'd0, e_tmo = 8'd0;
    logic [10:0] e_unl = 11'd0, e_lck = 11'd0;
    logic [2:0]  e_inv = 3'd0;

    block_sync_lane_supervisor dut (
        .i_clock               (clk),
        .i_reset_n             (rst_n),
        .i_enable              (enable),
        .i_valid               (valid),
        .i_signal_ok           (signal_ok),
        .i_lane_lock           (lane_lock),
        .i_cfg_unlocked_limit  (cfg_unl),
        .i_cfg_locked_limit    (cfg_lck),
        .i_cfg_invalid_limit   (cfg_inv),
        .i_cfg_timeout         (cfg_timeout),
        .i_cfg_qual            (cfg_qual),
        .i_clear_stats         (clear_stats),
        .o_lane_enable         (lane_enable),
        .o_lane_reset          (lane_reset),
        .o_unlocked_timer_limit(unl_lim),
        .o_locked_timer_limit  (lck_lim),
        .o_sh_invalid_limit    (inv_lim),
        .o_all_locked          (all_locked),
        .o_align_start         (align_start),
        .o_state               (state),
        .o_loss_count          (loss_count),
        .o_timeout_count       (timeout_count)
    );

    assign obs = '{state: state, all_locked: all_locked, align_start: align_start,
                   lane_enable: lane_enable, lane_reset: lane_reset, loss: loss_count,
                   tmo: timeout_count, unl: unl_lim, lck: lck_lim, inv: inv_lim};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk(input logic [2:0] st, input logic [19:0] lrst,
                                input logic al, input logic as);
        obs_t e;
        e.state       = st;
        e.all_locked  = al;
        e.align_start = as;
        e.lane_enable = (st == IDLE) ? 20'h0 : ALL;
        e.lane_reset  = lrst;
        e.loss        = e_loss;
        e.tmo         = e_tmo;
        e.unl         = e_unl;
        e.lck         = e_lck;
        e.inv         = e_inv;
        return e;
    endfunction

    task automatic check(input string tag);
        obs_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // Queue an expectation, advance n clock edges, then compare
    task automatic expect_in(input int n, input obs_t e, input string tag);
        exp_q.push_back(e);
        repeat (n) @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; valid = 1'b1; signal_ok = 1'b0; clear_stats = 1'b0;
        lane_lock = 20'h0;
        cfg_unl = 11'd100; cfg_lck = 11'd200; cfg_inv = 3'd5;
        cfg_timeout = 16'd0; cfg_qual = 8'd8;
        #12;
        expect_in(0, mk(IDLE, 20'h0, 1'b0, 1'b0), "reset");
        rst_n = 1'b1;
        e_unl = 11'd100; e_lck = 11'd200; e_inv = 3'd5;
        expect_in(1, mk(IDLE, ALL, 1'b0, 1'b0), "idle_no_signal");

        // Acquisition and qualification
        signal_ok = 1'b1;
        expect_in(1, mk(SEARCH, 20'h0, 1'b0, 1'b0), "enter_search");
        expect_in(99, mk(SEARCH, 20'h0, 1'b0, 1'b0), "search_100");
        lane_lock = ALL;
        expect_in(1, mk(QUALIFY, 20'h0, 1'b0, 1'b0), "enter_qualify");
        expect_in(7, mk(QUALIFY, 20'h0, 1'b0, 1'b0), "qualify_7");
        expect_in(1, mk(LOCKED, 20'h0, 1'b1, 1'b1), "locked_align");
        expect_in(1, mk(LOCKED, 20'h0, 1'b1, 1'b0), "align_one_cycle");

        // Config change while not idle must stay hidden
        cfg_unl = 11'd300; cfg_lck = 11'd400; cfg_inv = 3'd2;

        // Lock loss for one tick
        lane_lock = ALL & ~20'h1;
        e_loss = 8'd1;
        expect_in(1, mk(SEARCH, 20'h0, 1'b0, 1'b0), "lock_loss");
        lane_lock = ALL;
        expect_in(1, mk(QUALIFY, 20'h0, 1'b0, 1'b0), "requalify");
        expect_in(4, mk(QUALIFY, 20'h0, 1'b0, 1'b0), "qual_count4");
        lane_lock = ALL & ~(20'h1 << 5);
        expect_in(1, mk(SEARCH, 20'h0, 1'b0, 1'b0), "qual_drop_lane5");

        // Timeout with lane 3 never locking
        cfg_timeout = 16'd50;
        lane_lock = ALL & ~(20'h1 << 3);
        expect_in(49, mk(SEARCH, 20'h0, 1'b0, 1'b0), "pre_timeout");
        e_tmo = 8'd1;
        expect_in(1, mk(RESYNC, 20'h8, 1'b0, 1'b0), "resync_entry");
        expect_in(3, mk(RESYNC, 20'h8, 1'b0, 1'b0), "resync_hold");
        expect_in(1, mk(SEARCH, 20'h0, 1'b0, 1'b0), "resync_exit");

        // Lock completes on the same tick the timeout expires
        expect_in(49, mk(SEARCH, 20'h0, 1'b0, 1'b0), "pre_tie");
        lane_lock = ALL;
        expect_in(1, mk(QUALIFY, 20'h0, 1'b0, 1'b0), "tie_lock_wins");

        // Enable low freezes the qualify counter and cannot stretch align_start
        expect_in(3, mk(QUALIFY, 20'h0, 1'b0, 1'b0), "qual3");
        enable = 1'b0;
        expect_in(5, mk(QUALIFY, 20'h0, 1'b0, 1'b0), "frozen");
        enable = 1'b1;
        expect_in(4, mk(QUALIFY, 20'h0, 1'b0, 1'b0), "qual7_after_freeze");
        expect_in(1, mk(LOCKED, 20'h0, 1'b1, 1'b1), "locked_after_freeze");
        enable = 1'b0;
        expect_in(1, mk(LOCKED, 20'h0, 1'b1, 1'b0), "align_pulse_disabled");
        enable = 1'b1;

        // Loss counter saturation, zero qualify limit
        cfg_qual = 8'd0;
        for (int i = 0; i < 300; i++) begin
            lane_lock = ALL & ~20'h1;
            if (e_loss != 8'd255) e_loss = e_loss + 8'd1;
            expect_in(1, mk(SEARCH, 20'h0, 1'b0, 1'b0), "loss_sat");
            lane_lock = ALL;
            expect_in(2, mk(LOCKED, 20'h0, 1'b1, 1'b1), "relock_q0");
        end

        // Clear wins over a simultaneous increment
        lane_lock = ALL & ~(20'h1 << 3);
        clear_stats = 1'b1;
        e_loss = 8'd0; e_tmo = 8'd0;
        expect_in(1, mk(SEARCH, 20'h0, 1'b0, 1'b0), "clear_stats");
        clear_stats = 1'b0;

        // Signal loss on the timeout tick, then shadow reload in idle
        expect_in(49, mk(SEARCH, 20'h0, 1'b0, 1'b0), "pre_timeout2");
        signal_ok = 1'b0;
        expect_in(1, mk(IDLE, ALL, 1'b0, 1'b0), "signal_loss_over_timeout");
        e_unl = 11'd300; e_lck = 11'd400; e_inv = 3'd2;
        expect_in(1, mk(IDLE, ALL, 1'b0, 1'b0), "shadow_reload");
        signal_ok = 1'b1;
        lane_lock = ALL;
        expect_in(1, mk(SEARCH, 20'h0, 1'b0, 1'b0), "search_again");
        expect_in(1, mk(QUALIFY, 20'h0, 1'b0, 1'b0), "qualify_again");
        signal_ok = 1'b0;
        expect_in(1, mk(IDLE, ALL, 1'b0, 1'b0), "signal_loss_qualify");

        if (exp_q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
